// File: rtl/baseline_subtract.sv
`default_nettype none
// ============================================================================
//  Module   : baseline_subtract
//  Function : Latches the latest four-channel baseline and subtracts it from
//             each live 4x16-bit ADC sample word. Produces signed, saturated,
//             baseline-corrected samples after a 2-stage pipeline. Tracks the
//             age of the baseline and flags it as stale.
//  Options  : BL_SUB_ZS_EN - adds the zs_thresh input. Any corrected channel
//             with |value| < zs_thresh is forced to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module baseline_subtract #(
    parameter int ADC_BIT     = 16,
    parameter int AGE_W       = 16,
    parameter int STALE_LIMIT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active low
    input  logic                 bl_valid,
    input  logic [4*ADC_BIT-1:0] bl_data,
    input  logic                 bl_freeze,
    input  logic                 in_valid,
    input  logic [4*ADC_BIT-1:0] din,
`ifdef BL_SUB_ZS_EN
    input  logic [ADC_BIT-1:0]   zs_thresh,
`endif
    output logic                 out_valid,
    output logic [4*ADC_BIT-1:0] dout,
    output logic                 bl_loaded,
    output logic                 bl_stale,
    output logic [AGE_W-1:0]     bl_age,
    output logic [AGE_W-1:0]     drop_cnt
);

    localparam int               c_NCH     = 4;
    localparam logic [AGE_W-1:0] c_STALE   = AGE_W'(STALE_LIMIT);
    localparam logic [AGE_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        S_NOBL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [4*ADC_BIT-1:0] r_bl;
    logic                 r_s1Valid;
    logic [4*ADC_BIT-1:0] w_word;
    logic                 w_blAccept;
    logic                 w_sampleRun;
    logic                 w_sampleDrop;

    // A frozen strobe is ignored entirely.
    assign w_blAccept   = bl_valid & ~bl_freeze;
    assign w_sampleRun  = in_valid & (r_state == S_RUN);
    assign w_sampleDrop = in_valid & (r_state == S_NOBL);
    assign bl_loaded    = (r_state == S_RUN);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_NOBL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The first accepted baseline starts the run. After that, the block stays running until reset.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_NOBL:  if (w_blAccept) w_stateNext = S_RUN;
            S_RUN:   w_stateNext = S_RUN;
            default: w_stateNext = S_NOBL;
        endcase
    end

    // Baseline register. Samples arriving on the load cycle still see the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bl <= '0;
        end else if (w_blAccept) begin
            r_bl <= bl_data;
        end
    end

    // Per-channel datapath: subtract in stage 1, then saturate (and optionally suppress) before stage 2.
    for (genvar ch = 0; ch < c_NCH; ch++) begin : g_ch
        localparam int c_LO = ch * ADC_BIT;

        logic [ADC_BIT:0]   w_diffNow;
        logic [ADC_BIT:0]   r_diff;
        logic [ADC_BIT-1:0] w_sat;
        logic [ADC_BIT-1:0] w_chOut;

        assign w_diffNow = {1'b0, din[c_LO +: ADC_BIT]} - {1'b0, r_bl[c_LO +: ADC_BIT]};

        // Stage-1 difference register. It only updates on accepted samples.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_diff <= '0;
            end else if (w_sampleRun) begin
                r_diff <= w_diffNow;
            end
        end

        // The 17-bit difference overflows 16-bit signed exactly when its top two bits disagree.
        always_comb begin
            w_sat = r_diff[ADC_BIT-1:0];
            if (r_diff[ADC_BIT] != r_diff[ADC_BIT-1]) begin
                w_sat = r_diff[ADC_BIT] ? {1'b1, {(ADC_BIT-1){1'b0}}}
                                        : {1'b0, {(ADC_BIT-1){1'b1}}};
            end
        end

`ifdef BL_SUB_ZS_EN
        logic [ADC_BIT-1:0] w_abs;
        // Magnitude of the saturated value. Note that 0x8000 maps to 0x8000 as an unsigned value.
        assign w_abs   = w_sat[ADC_BIT-1] ? (~w_sat + 1'b1) : w_sat;
        assign w_chOut = (w_abs < zs_thresh) ? '0 : w_sat;
`else
        assign w_chOut = w_sat;
`endif

        assign w_word[c_LO +: ADC_BIT] = w_chOut;
    end

    // Pipeline valids and the output register. dout holds its value during gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1Valid <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else begin
            r_s1Valid <= w_sampleRun;
            out_valid <= r_s1Valid;
            if (r_s1Valid) begin
                dout <= w_word;
            end
        end
    end

    // Baseline age, drop counter and registered stale flag. Both counters saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bl_age   <= '0;
            drop_cnt <= '0;
            bl_stale <= 1'b0;
        end else begin
            bl_stale <= (bl_age >= c_STALE);
            if (w_blAccept) begin
                bl_age <= '0;
            end else if (w_sampleRun && (bl_age != c_CNT_MAX)) begin
                bl_age <= bl_age + AGE_W'(1);
            end
            if (w_sampleDrop && (drop_cnt != c_CNT_MAX)) begin
                drop_cnt <= drop_cnt + AGE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_baseline_subtract.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baseline_subtract
//  Function : Self-checking bench for baseline_subtract. Expected samples are
//             queued when the bench drives them and compared when out_valid
//             fires. Status outputs are compared against a cycle model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_baseline_subtract;

    localparam int LIM = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bl_valid = 1'b0;
    logic [63:0] bl_data = '0;
    logic        bl_freeze = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] din = '0;
    logic [15:0] zsThr = '0;
    logic        out_valid;
    logic [63:0] dout;
    logic        bl_loaded;
    logic        bl_stale;
    logic [15:0] bl_age;
    logic [15:0] drop_cnt;

    baseline_subtract #(
        .ADC_BIT    (16),
        .AGE_W      (16),
        .STALE_LIMIT(LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bl_valid (bl_valid),
        .bl_data  (bl_data),
        .bl_freeze(bl_freeze),
        .in_valid (in_valid),
        .din      (din),
`ifdef BL_SUB_ZS_EN
        .zs_thresh(zsThr),
`endif
        .out_valid(out_valid),
        .dout     (dout),
        .bl_loaded(bl_loaded),
        .bl_stale (bl_stale),
        .bl_age   (bl_age),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        longint      cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    longint      cyc = 0;
    int          nTotal = 0;
    int          nBad = 0;
    logic [63:0] lastDout = '0;

    // Reference model state.
    logic [63:0] mBl = '0;
    logic        mRun = 1'b0;
    logic [15:0] mAge = '0;
    logic [15:0] mDrop = '0;
    logic        mStale = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expWord(input logic [63:0] bl, input logic [63:0] d,
                                            input logic [15:0] thr);
        logic [63:0] r;
        int          diff;
        int          mag;
        r = '0;
        for (int ch = 0; ch < 4; ch++) begin
            diff = $signed({16'b0, d[ch*16 +: 16]}) - $signed({16'b0, bl[ch*16 +: 16]});
            if (diff > 32767)  diff = 32767;
            if (diff < -32768) diff = -32768;
            mag = (diff < 0) ? -diff : diff;
            if (mag < $signed({16'b0, thr})) diff = 0;
            r[ch*16 +: 16] = diff[15:0];
        end
        return r;
    endfunction

    // Drive one cycle of stimulus, advance the model, then compare the status outputs.
    task automatic step(input logic blv, input logic [63:0] bl, input logic frz,
                        input logic inv, input logic [63:0] d);
        logic acc;
        bl_valid  = blv;
        bl_data   = bl;
        bl_freeze = frz;
        in_valid  = inv;
        din       = d;
        acc = blv & ~frz;
        if (inv) begin
            if (mRun) q.push_back('{data: expWord(mBl, d, zsThr), cyc: cyc + 2});
            else if (mDrop != 16'hFFFF) mDrop++;
        end
        mStale = (mAge >= LIM);
        if (acc) mAge = '0;
        else if (inv && mRun && mAge != 16'hFFFF) mAge++;
        if (acc) begin
            mBl  = bl;
            mRun = 1'b1;
        end
        @(posedge clk);
        #1;
        bl_valid  = 1'b0;
        bl_freeze = 1'b0;
        in_valid  = 1'b0;
        chk("age", bl_age, mAge);
        chk("drop", drop_cnt, mDrop);
        chk("loaded", bl_loaded, mRun);
        chk("stale", bl_stale, mStale);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Asynchronous reset entry. All outputs must clear without waiting for a clock edge.
    task automatic doReset();
        rst = 1'b0;
        #1;
        q.delete();
        lastDout = '0;
        mBl = '0; mRun = 1'b0; mAge = '0; mDrop = '0; mStale = 1'b0;
        chk("rst_ov", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_loaded", bl_loaded, 0);
        chk("rst_stale", bl_stale, 0);
        chk("rst_age", bl_age, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Output monitor: pop and compare on out_valid, otherwise dout must hold its value.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_ov", {63'b0, out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("dout", dout, e.data);
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    lastDout = e.data;
                end
            end else begin
                chk("hold", dout, lastDout);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        doReset();

        // No baseline has been loaded yet, so every sample is dropped and counted.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 64'h0100_0200_0300_0400);
        chk("t1_drop3", drop_cnt, 3);

        // First load, then a basic subtraction.
        step(1'b1, 64'h0100_0100_0100_0100, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'h0180_0100_00F0_0000);
        idle(2);
        chk("t2_age1", bl_age, 1);

        // A load on the same cycle as a sample: that sample uses the old baseline.
        step(1'b1, 64'h0200_0200_0200_0200, 1'b0, 1'b1, 64'h0300_0300_0300_0300);
        step(1'b0, '0, 1'b0, 1'b1, 64'h0300_0300_0300_0300);
        chk("t3_age1", bl_age, 1);
        idle(2);

        // Saturation at both rails.
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'h0000_0000_0000_0000);
        step(1'b1, 64'h0000_0000_0000_0000, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(2);

        // A frozen strobe must not change the baseline or the age.
        step(1'b1, 64'h0100_0100_0100_0100, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'h0200_0200_0200_0200);
        step(1'b1, 64'h1234_1234_1234_1234, 1'b1, 1'b1, 64'h0300_0300_0300_0300);
        step(1'b0, '0, 1'b0, 1'b1, 64'h0300_0300_0300_0300);
        chk("t5_age_frz", bl_age, 3);

        // Stale flag: set after LIM samples, cleared one cycle after a reload.
        step(1'b1, 64'h0100_0100_0100_0100, 1'b0, 1'b0, '0);
        for (int i = 0; i < LIM; i++) step(1'b0, '0, 1'b0, 1'b1, 64'h0105_00FF_0100_0200);
        idle(1);
        chk("t5_stale_set", bl_stale, 1);
        step(1'b1, 64'h0080_0080_0080_0080, 1'b0, 1'b0, '0);
        idle(1);
        chk("t5_stale_clr", bl_stale, 0);

        // Random traffic with gaps, reloads and freezes.
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 5) == 0), {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0), {$urandom, $urandom});
        end
        idle(3);

`ifdef BL_SUB_ZS_EN
        // Zero suppression just below and exactly at the threshold, for both signs.
        zsThr = 16'h0010;
        step(1'b1, 64'h0100_0100_0100_0100, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 64'h010F_0110_00F1_00F0);
        idle(3);
        zsThr = 16'h0000;
        idle(1);
`endif

        // Reset with two samples in flight: nothing may emerge afterwards.
        step(1'b0, '0, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
        step(1'b0, '0, 1'b0, 1'b1, 64'h5555_6666_7777_8888);
        doReset();
        idle(4);
        step(1'b0, '0, 1'b0, 1'b1, 64'h0100_0100_0100_0100);
        chk("t6_drop1", drop_cnt, 1);
        idle(3);

        chk("drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
`default_nettype wire
